// File: rtl/wdivou_seq.sv
// Multi-cycle unsigned divider for WideWord odd subfields: each lane of reg_A is divided
// by the zero-extended odd subfield of the matching reg_B lane, one quotient bit per cycle.
module wdivou_seq (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] reg_A,
  input  logic [127:0] reg_B,
  input  logic [1:0]   ctrl_ww,
  output logic         busy,
  output logic         done,
  output logic [127:0] result,
  output logic [127:0] rem
);
  localparam logic [1:0] WW_8  = 2'b01;
  localparam logic [1:0] WW_16 = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [1:0]         ww_q, ww_d;
  logic [127:0]       result_q, result_d;
  logic [127:0]       rem_q, rem_d;
  logic [127:0]       q_q, q_d;
  logic [135:0]       r_q, r_d;
  logic [7:0][15:0]   d_q, d_d;

  logic [127:0]       q_step;
  logic [135:0]       r_step;
  logic [127:0]       rem_step;
  logic [7:0][15:0]   d_load;
  logic [32:0]        s16;
  logic [64:0]        s32;
  logic [5:0]         cnt_last;
  logic               unused_reg_b;

  // One restoring step for a 16-bit lane: returns {R(17), Q(16)}.
  function automatic logic [32:0] div_step16(input logic [16:0] r, input logic [15:0] q,
                                             input logic [15:0] d);
    logic [16:0]        r_sh;
    logic [15:0]        q_sh;
    logic signed [17:0] trial;
    r_sh  = {r[15:0], q[15]};
    q_sh  = {q[14:0], 1'b0};
    trial = $signed({1'b0, r_sh}) - $signed({2'b00, d});
    if (!trial[17]) begin
      r_sh    = trial[16:0];
      q_sh[0] = 1'b1;
    end
    return {r_sh, q_sh};
  endfunction

  // One restoring step for a 32-bit lane: returns {R(33), Q(32)}.
  function automatic logic [64:0] div_step32(input logic [32:0] r, input logic [31:0] q,
                                             input logic [15:0] d);
    logic [32:0]        r_sh;
    logic [31:0]        q_sh;
    logic signed [33:0] trial;
    r_sh  = {r[31:0], q[31]};
    q_sh  = {q[30:0], 1'b0};
    trial = $signed({1'b0, r_sh}) - $signed({18'd0, d});
    if (!trial[33]) begin
      r_sh    = trial[32:0];
      q_sh[0] = 1'b1;
    end
    return {r_sh, q_sh};
  endfunction

  // Partial remainders share one flat register: 8 x 17 bits or 4 x 33 bits.
  always_comb begin
    q_step   = q_q;
    r_step   = r_q;
    rem_step = '0;
    s16      = '0;
    s32      = '0;
    if (ww_q == WW_16) begin
      for (int k = 0; k < 4; k++) begin
        s32 = div_step32(r_q[34*k +: 33], q_q[96-32*k +: 32], d_q[k]);
        r_step[34*k +: 33]      = s32[64:32];
        q_step[96-32*k +: 32]   = s32[31:0];
        rem_step[96-32*k +: 32] = s32[63:32];
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        s16 = div_step16(r_q[17*k +: 17], q_q[112-16*k +: 16], d_q[k]);
        r_step[17*k +: 17]       = s16[32:16];
        q_step[112-16*k +: 16]   = s16[15:0];
        rem_step[112-16*k +: 16] = s16[31:16];
      end
    end
  end

  always_comb begin
    d_load = '0;
    if (ctrl_ww == WW_16) begin
      for (int k = 0; k < 4; k++) d_load[k] = reg_B[96-32*k +: 16];
    end else begin
      for (int k = 0; k < 8; k++) d_load[k] = {8'h00, reg_B[112-16*k +: 8]};
    end
  end

  // Even subfields of reg_B never reach the datapath.
  assign unused_reg_b = ^reg_B;
  assign cnt_last     = (ww_q == WW_16) ? 6'd31 : 6'd15;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ww_d     = ww_q;
    result_d = result_q;
    rem_d    = rem_q;
    q_d      = q_q;
    r_d      = r_q;
    d_d      = d_q;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_RUN: begin
        busy  = 1'b1;
        q_d   = q_step;
        r_d   = r_step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == cnt_last) begin
          result_d = q_step;
          rem_d    = rem_step;
          state_d  = S_DONE;
        end
      end
      default: begin
        done    = (state_q == S_DONE);
        state_d = S_IDLE;
        if (start) begin
          ww_d  = ctrl_ww;
          q_d   = reg_A;
          r_d   = '0;
          d_d   = d_load;
          cnt_d = '0;
          if (ctrl_ww == WW_8 || ctrl_ww == WW_16) begin
            state_d = S_RUN;
          end else begin
            // Unsupported width completes immediately with zeroed outputs.
            result_d = '0;
            rem_d    = '0;
            state_d  = S_DONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ww_q     <= '0;
      result_q <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ww_q     <= ww_d;
      result_q <= result_d;
      rem_q    <= rem_d;
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
    r_q <= r_d;
    d_q <= d_d;
  end

  assign result = result_q;
  assign rem    = rem_q;
endmodule

// File: tb/tb_wdivou_seq.sv
// Bench for wdivou_seq: directed table, multi-cycle corner sequences and random ops
// compared against a plain-arithmetic division model.
module tb_wdivou_seq;
  logic         clk = 1'b0;
  logic         reset, start;
  logic [127:0] reg_A, reg_B;
  logic [1:0]   ctrl_ww;
  logic         busy, done;
  logic [127:0] result, rem;

  int n_vec = 0;
  int n_bad = 0;

  wdivou_seq dut (
    .clk(clk), .reset(reset), .start(start), .reg_A(reg_A), .reg_B(reg_B),
    .ctrl_ww(ctrl_ww), .busy(busy), .done(done), .result(result), .rem(rem)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [1:0]   ww;
    logic [127:0] a, b, q, r;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference: per-lane integer division; zero divisor gives all-ones / dividend.
  function automatic void model(input logic [1:0] ww, input logic [127:0] a, b,
                                output logic [127:0] q, r);
    q = '0;
    r = '0;
    if (ww == 2'b01 || ww == 2'b10) begin
      int lanes = (ww == 2'b01) ? 8 : 4;
      int w     = (ww == 2'b01) ? 16 : 32;
      for (int k = 0; k < lanes; k++) begin
        longint unsigned av, dv, qv, rv, lmask, dmask;
        int sh = 128 - w * (k + 1);
        lmask = (64'd1 << w) - 1;
        dmask = (64'd1 << (w / 2)) - 1;
        av = 64'((a >> sh) & 128'(lmask));
        dv = 64'((b >> sh) & 128'(dmask));
        qv = (dv == 0) ? lmask : av / dv;
        rv = (dv == 0) ? av : av % dv;
        q  = q | (128'(qv) << sh);
        r  = r | (128'(rv) << sh);
      end
    end
  endfunction

  function automatic int exp_latency(input logic [1:0] ww);
    return (ww == 2'b01) ? 17 : (ww == 2'b10) ? 33 : 1;
  endfunction

  task automatic issue(input logic [1:0] ww, input logic [127:0] a, b);
    @(negedge clk);
    start = 1'b1; ctrl_ww = ww; reg_A = a; reg_B = b;
    @(posedge clk);
    #1;
    start   = 1'b0;
    reg_A   = {$urandom, $urandom, $urandom, $urandom};
    reg_B   = {$urandom, $urandom, $urandom, $urandom};
    ctrl_ww = 2'($urandom);
  endtask

  task automatic wait_done(input int c0, output int lat, output int busy_cyc, output int overlap);
    int c = c0;
    lat = -1; busy_cyc = 0; overlap = 0;
    while (lat < 0 && c < c0 + 100) begin
      @(negedge clk);
      c++;
      if (busy && done) overlap++;
      if (busy) busy_cyc++;
      if (done) lat = c;
    end
  endtask

  task automatic run_vec(input string name, input logic [1:0] ww, input logic [127:0] a, b, q, r);
    int lat, bc, ov;
    issue(ww, a, b);
    wait_done(0, lat, bc, ov);
    check($sformatf("%s.latency", name), 128'(lat), 128'(exp_latency(ww)));
    check($sformatf("%s.busy_cycles", name), 128'(bc), 128'(exp_latency(ww) - 1));
    check($sformatf("%s.busy_done_overlap", name), 128'(ov), 128'd0);
    check($sformatf("%s.result", name), result, q);
    check($sformatf("%s.rem", name), rem, r);
    @(negedge clk);
    check($sformatf("%s.done_pulse", name), 128'(done), 128'd0);
    check($sformatf("%s.result_hold", name), result, q);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  initial begin
    int lat, bc, ov, nd;
    logic [63:0] got_d, exp_d, got_b, exp_b;
    logic [127:0] mq, mr, ra, rb;
    logic [1:0] rww;

    tbl[0] = '{"ww8_basic", 2'b01, {16'h03E8, 112'h0}, {16'hFF07, {7{16'h0001}}},
               {16'd142, 112'h0}, {16'd6, 112'h0}};
    tbl[1] = '{"ww16_basic", 2'b10, {32'd7, 32'd7, 32'd100000, 32'd7},
               {16'hABCD, 16'd2, 16'hABCD, 16'd2, 16'h1111, 16'd300, 16'hABCD, 16'd2},
               {32'd3, 32'd3, 32'd333, 32'd3}, {32'd1, 32'd1, 32'd100, 32'd1}};
    tbl[2] = '{"ww8_div0", 2'b01, {{3{16'd100}}, 16'h1234, {4{16'd100}}},
               {{3{16'h0007}}, 16'h5500, {4{16'h0007}}},
               {{3{16'd14}}, 16'hFFFF, {4{16'd14}}}, {{3{16'd2}}, 16'h1234, {4{16'd2}}}};
    tbl[3] = '{"ww00_unsup", 2'b00, {4{32'hCAFEF00D}}, {8{16'h0003}}, 128'h0, 128'h0};
    tbl[4] = '{"ww11_unsup", 2'b11, {4{32'h12345678}}, {8{16'h0005}}, 128'h0, 128'h0};
    tbl[5] = '{"ww16_div0", 2'b10, {32'hDEADBEEF, {3{32'd50}}}, {32'hFFFF0000, {3{32'h00000007}}},
               {32'hFFFFFFFF, {3{32'd7}}}, {32'hDEADBEEF, {3{32'd1}}}};
    tbl[6] = '{"ww8_max", 2'b01, {8{16'hFFFF}}, {4{16'h00FF, 16'h0001}},
               {4{16'h0101, 16'hFFFF}}, 128'h0};
    tbl[7] = '{"ww16_max", 2'b10, {4{32'hFFFFFFFF}}, {4{32'h0000FFFF}},
               {4{32'h00010001}}, 128'h0};

    reset = 1'b1; start = 1'b0; ctrl_ww = 2'b00; reg_A = '0; reg_B = '0;
    repeat (3) @(negedge clk);
    check("reset.busy", 128'(busy), 128'd0);
    check("reset.done", 128'(done), 128'd0);
    check("reset.result", result, 128'd0);
    check("reset.rem", rem, 128'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(tbl[i].name, tbl[i].ww, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r);

    // A start pulse during RUN must not disturb or queue anything.
    issue(tbl[0].ww, tbl[0].a, tbl[0].b);
    repeat (5) @(negedge clk);
    start = 1'b1; ctrl_ww = 2'b10; reg_A = {4{32'h55555555}}; reg_B = {8{16'h0003}};
    @(negedge clk);
    start = 1'b0;
    wait_done(6, lat, bc, ov);
    check("ignored_start.latency", 128'(lat), 128'd17);
    check("ignored_start.result", result, tbl[0].q);
    check("ignored_start.rem", rem, tbl[0].r);
    count_dones(40, nd);
    check("ignored_start.no_queue", 128'(nd), 128'd0);

    // start held high: one done every 17 cycles, busy in every other cycle.
    @(negedge clk);
    start = 1'b1; ctrl_ww = tbl[2].ww; reg_A = tbl[2].a; reg_B = tbl[2].b;
    got_d = '0; exp_d = '0; got_b = '0; exp_b = '0;
    for (int c = 1; c <= 51; c++) begin
      @(negedge clk);
      got_d[c] = done;
      got_b[c] = busy;
      exp_d[c] = (c % 17 == 0);
      exp_b[c] = (c % 17 != 0);
    end
    start = 1'b0;
    check("b2b.done_pattern", 128'(got_d), 128'(exp_d));
    check("b2b.busy_pattern", 128'(got_b), 128'(exp_b));
    check("b2b.result", result, tbl[2].q);
    check("b2b.rem", rem, tbl[2].r);
    count_dones(20, nd);
    check("b2b.stops", 128'(nd), 128'd0);

    // Reset in cycle 8 of a ww=16 run aborts it without a done.
    issue(tbl[1].ww, tbl[1].a, tbl[1].b);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort.busy", 128'(busy), 128'd0);
    check("abort.done", 128'(done), 128'd0);
    check("abort.result", result, 128'd0);
    check("abort.rem", rem, 128'd0);
    count_dones(40, nd);
    check("abort.no_done", 128'(nd), 128'd0);
    run_vec("after_abort", tbl[1].ww, tbl[1].a, tbl[1].b, tbl[1].q, tbl[1].r);

    // Reset and start on the same edge: the request is dropped.
    @(negedge clk);
    reset = 1'b1; start = 1'b1; ctrl_ww = tbl[0].ww; reg_A = tbl[0].a; reg_B = tbl[0].b;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_start.busy", 128'(busy), 128'd0);
    check("rst_start.result", result, 128'd0);
    count_dones(30, nd);
    check("rst_start.no_done", 128'(nd), 128'd0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0:       rww = 2'b00;
        1:       rww = 2'b11;
        2, 3, 4: rww = 2'b01;
        default: rww = 2'b10;
      endcase
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 3))
        1:       rb = rb & {8{16'hFF03}};
        2:       rb = rb & {8{16'hFF00}};
        3:       rb = rb & {4{32'hFFFF000F}};
        default: ;
      endcase
      model(rww, ra, rb, mq, mr);
      run_vec($sformatf("rand%0d_ww%0b", i, rww), rww, ra, rb, mq, mr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/wdivou_seq.md
# wdivou_seq

Multi-cycle unsigned divider for the odd subfields of the Troy WideWord datapath. It is the inverse of the odd-subfield unsigned multiply: each double-width lane of `reg_A` is divided by the zero-extended odd subfield of the matching lane of `reg_B`. All lanes run in parallel as a restoring shift-subtract divider, one quotient bit per cycle. The block sits beside the ALU and uses a start/busy/done handshake with the execute-stage controller.

## Interface

Parameters:
- None. Lane geometry is fixed by `ctrl_ww`.

Ports:
- `clk`  in  1  — Single clock; all state updates on the rising edge.
- `reset`  in  1  — Synchronous, active-high; one clock, reset is synchronous and active-high.
- `start`  in  1  — Request. Operands and `ctrl_ww` are sampled on the edge where `start`=1 and the block is not busy.
- `reg_A`  in  128  — Dividend vector. Bit 0 is the MSB.
- `reg_B`  in  128  — Divisor source vector. Bit 0 is the MSB.
- `ctrl_ww`  in  2  — Lane width select.
  - 2'b01: 8 lanes of 16 bits; divisor is lane bits [8:15].
  - 2'b10: 4 lanes of 32 bits; divisor is lane bits [16:31].
  - Other values are unsupported.
- `busy`  out  1  — High while iterating.
- `done`  out  1  — One-cycle pulse when `result`/`rem` become valid.
- `result`  out  128  — Per-lane quotients at full lane width.
- `rem`  out  128  — Per-lane remainders, zero-extended to lane width.

## Operation

- States: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 latches `reg_A` into the quotient/dividend shift register.
  - It latches the zero-extended odd-subfield divisors and `ctrl_ww`, clears the partial remainders, and sets cnt=0.
  - It moves to RUN. `start`=0 stays in IDLE.
- RUN, per lane per cycle (lane width W = 16 or 32):
  - Shift {R, Q} left by 1. R is W bits wide plus one guard bit.
  - Compute trial = R − D.
  - If trial ≥ 0: R = trial and Q[lsb] = 1. Otherwise R is unchanged and Q[lsb] = 0.
  - Increment cnt. After step W, load `result` with Q and `rem` with R, then go to DONE.
- DONE:
  - `done`=1 for exactly one cycle, then IDLE.
  - `start`=1 in DONE is accepted exactly as in IDLE, so back-to-back operations are allowed.
- `start` while in RUN is ignored. It is not queued.
- Unsupported `ctrl_ww`: go IDLE → DONE with no RUN cycles. `result`=0 and `rem`=0.
- Divide by zero falls out of the algorithm unmodified and is required behaviour:
  - Quotient is all ones for the lane width (16'hFFFF or 32'hFFFF_FFFF).
  - Remainder equals the dividend.
- Widths and ignored bits:
  - No saturation and no overflow are possible: the quotient fits in W bits.
  - The even subfield of each `reg_B` lane is ignored.
- `result` and `rem` hold their values from DONE until the next DONE.
- Inputs may change freely after the accepting edge.

## Timing

- Reset values: state=IDLE, `busy`=0, `done`=0, `result`=128'd0, `rem`=128'd0, cnt=0.
- Cycle numbering, with `start` sampled high at the end of cycle 0:
  - `busy`=1 in cycles 1..W.
  - `done`=1 and outputs valid in cycle W+1.
  - Latency is therefore 17 cycles for ww=8 and 33 cycles for ww=16.
  - `busy` and `done` are never high together.
- Back-to-back: `start` in cycle W+1 gives `busy` in cycle W+2.
- Reset mid-RUN or in DONE:
  - The next cycle is IDLE with all outputs at their reset values.
  - The partial result is discarded, and no `done` is issued for the aborted operation.
- Reset and `start` on the same edge: reset wins and the request is dropped.

## Test plan

- **ww=8 basic:** `ctrl_ww`=01, lane 0 A=16'd1000, B lane 0=16'hFF07, other lanes A=0 and B=1, pulse `start` → `done` in cycle 17.
  - Lane 0: `result`[0:15]=16'd142, `rem`[0:15]=16'd6.
  - Other lanes: `result`=0, `rem`=0.
  - Shows that the even divisor byte 8'hFF is ignored.
- **ww=16 basic:** `ctrl_ww`=10, lane 2 A=32'd100000, B[80:95]=16'd300, other lanes A=7 and B divisor=2 → `done` in cycle 33.
  - Lane 2: `result`[64:95]=333, `rem`=100.
  - Other lanes: `result`=3, `rem`=1.
- **Divide by zero:** ww=8, lane 3 A=16'h1234, divisor=0 → `result`[48:63]=16'hFFFF, `rem`[48:63]=16'h1234.
- **Back-to-back and ignored start:**
  - Hold `start`=1 continuously from cycle 0 → exactly one `done` per 17 cycles.
  - A `start` pulse in cycle 5 of RUN changes nothing: outputs still match the first request.
- **Reset mid-operation:** assert `reset` in cycle 8 of a ww=16 run → `busy`=0 next cycle, no `done` for the aborted operation, `result`=`rem`=0; a fresh request then completes normally.
- **Unsupported width:** `ctrl_ww`=00 with `start` → `done` in cycle 1, `busy` never high, `result`=`rem`=0.
